serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 126 ++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flip-flop process
// one operand bit per clock, LSB first, and assemble the result in a shift register.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             borrow,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             mode_r;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             x;
  logic             y;
  logic             s;
  logic             c_next;
  logic             last_bit;

  // Subtraction is a + ~b + 1: b is inverted bit by bit and the carry starts at mode.
  assign x        = a_sh[0];
  assign y        = b_sh[0] ^ mode_r;
  assign s        = x ^ y ^ c;
  assign c_next   = ((x ^ y) & c) | (x & y);
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      mode_r   <= 1'b0;
      c        <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      cout     <= 1'b0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            mode_r <= mode;
            c      <= mode;
            cnt    <= '0;
          end
        end
        SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          result <= {s, result[WIDTH-1:1]};
          c      <= c_next;
          cnt    <= cnt + 1'b1;
          // Flags are taken while c still holds the carry into the MSB.
          if (last_bit) begin
            cout     <= c_next;
            borrow   <= mode_r & ~c_next;
            overflow <= c ^ c_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
